// File: rtl/mac_bist_controller.sv
// BIST sequencer for a 256-lane MAC slice: walks a one-hot activation through
// zero weights (stuck-at screen), then all-ones weights (bridging-fault screen).
module mac_bist_controller #(
    parameter int          MAC_LAT    = 1,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] NOMINAL    = 16'd15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   mac_sum,
    output logic [255:0]  in_array,
    output logic [1023:0] weight_array,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [2:0]    fault_code,
    output logic [7:0]    fault_index,
    output logic [15:0]   fault_sum
);

    typedef enum logic [2:0] {IDLE, S1_RUN, GAP, S2_RUN, DONE} state_t;

    localparam int          CNT_MAX    = (MAC_LAT > GAP_CYCLES) ? MAC_LAT : GAP_CYCLES;
    localparam int          CNT_W      = $clog2(CNT_MAX + 1) + 1;
    localparam logic [CNT_W-1:0] CHECK_CNT = CNT_W'(MAC_LAT);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [15:0] NOMINAL_X2 = NOMINAL << 1;
    localparam logic [1023:0] ALL_ONES = {256{4'b1111}};

    state_t            state_q;
    logic [7:0]        index_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       prev_sum_q;
    logic [255:0]      in_array_q;
    logic [1023:0]     weight_array_q;
    logic              busy_q, done_q, fault_q;
    logic [2:0]        fault_code_q;
    logic [7:0]        fault_index_q;
    logic [15:0]       fault_sum_q;
    logic [2:0]        s2_code_d;

    // Stage-2 bridging classification on the previous/current pattern pair.
    // NOTE: assign a default first so every path writes s2_code_d and no latch is inferred.
    always_comb begin
        s2_code_d = 3'd0;
        if (prev_sum_q == 16'd0 && mac_sum == 16'd0)
            s2_code_d = 3'd2;
        else if ((prev_sum_q == NOMINAL_X2 && mac_sum == 16'd0) ||
                 (prev_sum_q == 16'd0 && mac_sum == NOMINAL_X2))
            s2_code_d = 3'd3;
        else if (prev_sum_q == 16'd0 && mac_sum == NOMINAL)
            s2_code_d = 3'd4;
        else if (prev_sum_q == NOMINAL_X2 && mac_sum == NOMINAL_X2)
            s2_code_d = 3'd5;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            index_q        <= '0;
            cnt_q          <= '0;
            prev_sum_q     <= '0;
            in_array_q     <= '0;
            weight_array_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fault_q        <= 1'b0;
            fault_code_q   <= '0;
            fault_index_q  <= '0;
            fault_sum_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q        <= S1_RUN;
                        index_q        <= '0;
                        cnt_q          <= '0;
                        in_array_q     <= 256'd1;
                        weight_array_q <= '0;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        fault_q        <= 1'b0;
                        fault_code_q   <= '0;
                        fault_index_q  <= '0;
                        fault_sum_q    <= '0;
                    end
                end
                S1_RUN: begin
                    if (cnt_q != CHECK_CNT) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (mac_sum != 16'd0) begin
                        fault_q        <= 1'b1;
                        fault_code_q   <= 3'd1;
                        fault_index_q  <= index_q;
                        fault_sum_q    <= mac_sum;
                        state_q        <= DONE;
                        in_array_q     <= '0;
                        weight_array_q <= '0;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                    end else if (index_q == 8'd255) begin
                        state_q        <= GAP;
                        cnt_q          <= '0;
                        in_array_q     <= '0;
                        weight_array_q <= ALL_ONES;
                    end else begin
                        index_q    <= index_q + 8'd1;
                        in_array_q <= 256'd1 << (index_q + 8'd1);
                        cnt_q      <= '0;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q    <= S2_RUN;
                        index_q    <= '0;
                        cnt_q      <= '0;
                        in_array_q <= 256'd1;
                        prev_sum_q <= NOMINAL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S2_RUN: begin
                    if (cnt_q != CHECK_CNT) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (s2_code_d != 3'd0 || index_q == 8'd255) begin
                        if (s2_code_d != 3'd0) begin
                            fault_q       <= 1'b1;
                            fault_code_q  <= s2_code_d;
                            fault_index_q <= index_q;
                            fault_sum_q   <= mac_sum;
                        end else begin
                            prev_sum_q <= mac_sum;
                        end
                        state_q        <= DONE;
                        in_array_q     <= '0;
                        weight_array_q <= '0;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                    end else begin
                        prev_sum_q <= mac_sum;
                        index_q    <= index_q + 8'd1;
                        in_array_q <= 256'd1 << (index_q + 8'd1);
                        cnt_q      <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_array     = in_array_q;
    assign weight_array = weight_array_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;
    assign fault_index  = fault_index_q;
    assign fault_sum    = fault_sum_q;

endmodule

// File: tb/tb_mac_bist_controller.sv
// Directed bench: a behavioural MAC slice with injectable faults drives the controller.
module tb_mac_bist_controller;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   mac_sum;
    logic [255:0]  in_array;
    logic [1023:0] weight_array;
    logic          busy, done, fault;
    logic [2:0]    fault_code;
    logic [7:0]    fault_index;
    logic [15:0]   fault_sum;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    int          s1_stuck = -1;
    logic        ov_en  [256];
    logic [15:0] ov_val [256];

    mac_bist_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mac_sum(mac_sum),
        .in_array(in_array), .weight_array(weight_array), .busy(busy),
        .done(done), .fault(fault), .fault_code(fault_code),
        .fault_index(fault_index), .fault_sum(fault_sum)
    );

    always #5 clk = ~clk;

    // Active lane's weight nibble, unless a fault override applies to that lane.
    function automatic logic [15:0] model(input logic [255:0] act, input logic [1023:0] w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            if (act[i]) begin
                if (w == '0 && i == s1_stuck) r = 16'd15;
                else if (w != '0 && ov_en[i]) r = ov_val[i];
                else r = {12'd0, w[i*4 +: 4]};
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mac_sum <= '0;
        else        mac_sum <= model(in_array, weight_array);
    end

    always @(negedge clk) if (done && busy) overlap_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        s1_stuck = -1;
        for (int i = 0; i < 256; i++) begin
            ov_en[i]  = 1'b0;
            ov_val[i] = '0;
        end
    endtask

    task automatic set_ov(input int idx, input logic [15:0] v);
        ov_en[idx]  = 1'b1;
        ov_val[idx] = v;
    endtask

    // Pulses start and checks the start-edge state; returns with edge 0 just taken.
    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy0"}, busy, 1);
        check({tag, "_clr"}, {done, fault, fault_code, fault_index, fault_sum}, 0);
    endtask

    // Counts edges after the start edge until done; optional mid-run start pulse and probes.
    task automatic wait_done(input string tag, input int pulse_at, input bit probe, output int n);
        n = 0;
        while (n < 2000) begin
            if (n == pulse_at) begin
                @(negedge clk);
                start = 1'b1;
            end
            @(posedge clk);
            n++;
            #1;
            if (n == pulse_at + 1) start = 1'b0;
            if (probe && n == 1)
                check({tag, "_s1pat"}, {31'd0, in_array == 256'd1 && weight_array == '0}, 1);
            if (probe && n == 513)
                check({tag, "_gap"}, {31'd0, in_array == '0 && weight_array == {256{4'hF}}}, 1);
            if (probe && n == 515)
                check({tag, "_s2pat"}, {31'd0, in_array == 256'd1 && weight_array == {256{4'hF}}}, 1);
            if (done) break;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic run_case(input string tag, input int exp_n, input logic [2:0] code,
                            input logic [7:0] idx, input logic [15:0] sum,
                            input int pulse_at, input bit probe);
        int n;
        do_start(tag);
        wait_done(tag, pulse_at, probe, n);
        check({tag, "_cycles"}, n, exp_n);
        check({tag, "_fault"}, fault, (code != 0));
        check({tag, "_code"}, fault_code, code);
        check({tag, "_index"}, fault_index, idx);
        check({tag, "_sum"}, fault_sum, sum);
        check({tag, "_idle_out"}, {busy, |in_array, |weight_array}, 0);
    endtask

    initial begin
        clear_faults();
        #12;
        check("reset_outs", {busy, done, fault, fault_code, fault_index, fault_sum}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_run", {busy, done}, 0);

        // Clean run with a start pulse ignored mid stage 1.
        run_case("clean", 1026, 3'd0, 8'd0, 16'd0, 100, 1'b1);

        clear_faults();
        s1_stuck = 11;
        run_case("stuck", 24, 3'd1, 8'd11, 16'd15, -5, 1'b0);

        clear_faults();
        set_ov(20, 16'd0);  set_ov(21, 16'd0);
        run_case("wand", 558, 3'd2, 8'd21, 16'd0, -5, 1'b0);

        clear_faults();
        set_ov(20, 16'd30); set_ov(21, 16'd0);
        run_case("dor", 558, 3'd3, 8'd21, 16'd0, -5, 1'b0);

        clear_faults();
        set_ov(20, 16'd0);  set_ov(21, 16'd15);
        run_case("dand", 558, 3'd4, 8'd21, 16'd15, -5, 1'b0);

        clear_faults();
        set_ov(20, 16'd30); set_ov(21, 16'd30);
        run_case("wor", 558, 3'd5, 8'd21, 16'd30, -5, 1'b0);

        // Reset in the middle of stage 2 forces everything low immediately.
        clear_faults();
        do_start("rst");
        repeat (600) @(posedge clk);
        #2;
        check("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {busy, done, fault, fault_code, fault_index, fault_sum}, 0);
        check("rst_arrays", {|in_array, |weight_array}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_stay_idle", {busy, done, |in_array}, 0);

        run_case("rerun", 1026, 3'd0, 8'd0, 16'd0, -5, 1'b0);

        check("done_busy_overlap", overlap_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
